stack_dump: RTL and testbench

//  Debug reader for the data/return stack RAM. On request it freezes the CPU (hold -> wait_state),

---
 rtl/stack_dump.sv | 200 ++++++++++++++++++++
 tb/tb_stack_dump.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_dump.sv
// stack_dump: debug reader for the data/return stack RAM.
// On start it raises hold (ORed into the CPU wait_state), captures SP once the
// CPU is frozen, walks the stack from top-of-stack downward through the async
// read port and streams each entry on a valid/ready link.
// Optional feature: define STACK_DUMP_ANNOTATE_EN to prefix every dump with a
// header beat carrying the captured SP (zero-extended to the data width).
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for start; depth is clamped and latched on start
// FREEZE | hold asserted; SP is stable and captured at the end of this cycle
// LOAD   | rd_data copied into the output register, pointer steps down
// SEND   | beat presented on out_valid, held until out_ready
// DONE   | one-cycle completion pulse, hold already released
module stack_dump #(
    parameter int saddr_width = 8,
    parameter int width       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [saddr_width:0]   depth,
    input  logic [saddr_width-1:0] sp,
    output logic [saddr_width-1:0] rd_addr,
    input  logic [width-1:0]       rd_data,
    output logic                   hold,
    output logic                   busy,
    output logic                   out_valid,
    output logic [width-1:0]       out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic                   done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FREEZE = 3'd1,
        S_LOAD   = 3'd2,
        S_SEND   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Full stack size; any larger request is clamped to this.
    localparam logic [saddr_width:0]   MAX_DEPTH = {1'b1, {saddr_width{1'b0}}};
    localparam logic [saddr_width:0]   ONE_CNT   = {{saddr_width{1'b0}}, 1'b1};
    localparam logic [saddr_width-1:0] ONE_ADDR  = {{(saddr_width-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_next;
    logic [saddr_width:0]   r_count;
    logic [saddr_width-1:0] r_ptr;
    logic [saddr_width-1:0] r_rd_addr;
    logic [width-1:0]       r_out_data;
    logic                   r_out_last;
    logic                   r_out_valid;
    logic                   r_hold;
    logic                   r_busy;
    logic                   r_done;

    logic [saddr_width:0]   w_depth_clamped;
    logic [saddr_width-1:0] w_ptr_dec;
    logic                   w_abort;
    logic                   w_handshake;

`ifdef STACK_DUMP_ANNOTATE_EN
    logic [width-1:0]       w_sp_ext;
`endif

    // Request sizing, pointer step and qualified control events.
    always_comb begin
        w_depth_clamped = (depth > MAX_DEPTH) ? MAX_DEPTH : depth;
        w_ptr_dec       = r_ptr - ONE_ADDR;
        w_abort         = abort && (r_state != S_IDLE);
        w_handshake     = (r_state == S_SEND) && out_ready;
    end

`ifdef STACK_DUMP_ANNOTATE_EN
    // Header payload: captured SP widened to the beat width.
    always_comb begin
        w_sp_ext = width'(sp);
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_FREEZE;
                end
            end
            S_FREEZE: begin
`ifdef STACK_DUMP_ANNOTATE_EN
                w_next = S_SEND;
`else
                w_next = (r_count != '0) ? S_LOAD : S_DONE;
`endif
            end
            S_LOAD: begin
                w_next = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    w_next = (r_count != '0) ? S_LOAD : S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    // Status outputs registered from the next state so they are glitch-free
    // and all drop together on abort or reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold      <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_hold      <= (w_next == S_FREEZE) || (w_next == S_LOAD) ||
                           (w_next == S_SEND);
            r_busy      <= (w_next != S_IDLE);
            r_out_valid <= (w_next == S_SEND);
            r_done      <= (w_next == S_DONE);
        end
    end

    // Datapath: entry count, stack pointer walk, read address and beat data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_ptr      <= '0;
            r_rd_addr  <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count <= w_depth_clamped;
                    end
                end
                S_FREEZE: begin
                    // hold was high all of this cycle, so sp is frozen here.
                    r_ptr     <= sp;
                    r_rd_addr <= sp;
`ifdef STACK_DUMP_ANNOTATE_EN
                    r_out_data <= w_sp_ext;
                    r_out_last <= (r_count == '0);
`endif
                end
                S_LOAD: begin
                    r_out_data <= rd_data;
                    r_out_last <= (r_count == ONE_CNT);
                    r_count    <= r_count - ONE_CNT;
                    r_ptr      <= w_ptr_dec;
                    r_rd_addr  <= w_ptr_dec;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        r_out_last <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
            if (w_abort) begin
                r_out_last <= 1'b0;
            end
        end
    end

    assign rd_addr   = r_rd_addr;
    assign hold      = r_hold;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign done      = r_done;

endmodule

// File: tb/tb_stack_dump.sv
// Bench for stack_dump: scenario tasks plus a randomized run, all compared
// against a queue-based model of what a top-down stack dump must produce.
`timescale 1ns/1ps
module tb_stack_dump;
    localparam int SAW  = 8;
    localparam int W    = 16;
    localparam int NENT = 256;
`ifdef STACK_DUMP_ANNOTATE_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [SAW:0]   depth = '0;
    logic [SAW-1:0] sp = '0;
    logic [SAW-1:0] rd_addr;
    logic [W-1:0]   rd_data;
    logic           hold, busy, out_valid, out_last, out_ready, done;
    logic [W-1:0]   out_data;

    logic [W-1:0]   mem [NENT];

    int checks = 0;
    int errors = 0;

    // Captured behaviour of one dump.
    logic [W-1:0]   got_data[$];
    bit             got_last[$];
    logic [SAW-1:0] got_addr[$];
    int first_valid_k, done_k, done_pulses, hold_errs, stab_errs, timeout;

    // Model expectations.
    logic [W-1:0]   exp_data[$];
    bit             exp_last[$];
    logic [SAW-1:0] exp_addr[$];

    stack_dump #(.saddr_width(SAW), .width(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .depth(depth), .sp(sp), .rd_addr(rd_addr), .rd_data(rd_data),
        .hold(hold), .busy(busy), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .done(done)
    );

    assign rd_data = mem[rd_addr];

    always #5 clk = ~clk;

    task automatic fill_mem();
        for (int i = 0; i < NENT; i++) mem[i] = W'($urandom);
    endtask

    // Dump contents: optional SP header, then mem[SP], mem[SP-1], ... mod 256.
    function automatic void build_expected(input logic [SAW-1:0] spv, input int dep);
        int n;
        logic [SAW-1:0] a;
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        n = (dep > NENT) ? NENT : dep;
        if (HDR == 1) begin
            exp_data.push_back(W'(spv));
            exp_last.push_back(n == 0);
        end
        for (int i = 0; i < n; i++) begin
            a = SAW'(int'(spv) - i + NENT);
            exp_addr.push_back(a);
            exp_data.push_back(mem[a]);
            exp_last.push_back(i == n - 1);
        end
    endfunction

    // Runs one dump, recording beats and timing; k counts cycles after the
    // edge that samples start (k=1 is the freeze cycle).
    task automatic do_dump(input logic [SAW-1:0] spv, input int dep, input int rdy_pct,
                           input int stall_beat, input int stall_len, input int poke_k);
        int k, stall_cnt;
        logic rdy, prev_valid, prev_hs, prev_last;
        logic [W-1:0] prev_data;
        got_data.delete(); got_last.delete(); got_addr.delete();
        first_valid_k = -1; done_k = -1; done_pulses = 0;
        hold_errs = 0; stab_errs = 0; timeout = 0;
        stall_cnt = 0; prev_valid = 0; prev_hs = 0; prev_last = 0; prev_data = '0;
        @(negedge clk);
        sp = spv; depth = (SAW+1)'(dep); start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        k = 1;
        while (k < 5000) begin
            start = (k == poke_k);
            if (!busy) break;
            if (out_valid && first_valid_k < 0) first_valid_k = k;
            if (done) begin done_pulses++; done_k = k; end
            if (hold !== (busy && !done)) hold_errs++;
            if (busy && hold && !out_valid && k >= 2) got_addr.push_back(rd_addr);
            if (prev_valid && !prev_hs &&
                (!out_valid || out_data !== prev_data || out_last !== prev_last)) stab_errs++;
            if (stall_beat >= 0 && got_data.size() == stall_beat && stall_cnt < stall_len) begin
                rdy = 1'b0;
                if (out_valid) stall_cnt++;
            end else begin
                rdy = ($urandom_range(99) < rdy_pct);
            end
            out_ready = rdy;
            prev_valid = out_valid; prev_hs = out_valid && rdy;
            prev_data = out_data; prev_last = out_last;
            if (out_valid && rdy) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
            @(negedge clk);
            k++;
        end
        if (k >= 5000) timeout = 1;
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({hold, busy, out_valid, out_last, done} !== 5'b0)
            begin errors++; $display("FAIL reset_ctrl got %b want 00000", {hold, busy, out_valid, out_last, done}); end
        checks++;
        if (out_data !== '0 || rd_addr !== '0)
            begin errors++; $display("FAIL reset_data got data=%h addr=%h want 0/0", out_data, rd_addr); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        fill_mem();
        mem[5] = 16'hA11A; mem[4] = 16'hB22B; mem[3] = 16'hC33C;
        do_dump(8'd5, 3, 100, -1, 0, -1);
        checks++;
        if (got_data.size() != 3 + HDR)
            begin errors++; $display("FAIL basic_count got %0d want %0d", got_data.size(), 3 + HDR); end
        else begin
            checks++;
            if ({got_data[HDR], got_data[HDR+1], got_data[HDR+2]} !== {16'hA11A, 16'hB22B, 16'hC33C})
                begin errors++; $display("FAIL basic_data got %h %h %h want a11a b22b c33c", got_data[HDR], got_data[HDR+1], got_data[HDR+2]); end
            checks++;
            if ({got_last[HDR], got_last[HDR+1], got_last[HDR+2]} !== 3'b001)
                begin errors++; $display("FAIL basic_last got %b%b%b want 001", got_last[HDR], got_last[HDR+1], got_last[HDR+2]); end
        end
        checks++;
        if (first_valid_k != 3 - HDR)
            begin errors++; $display("FAIL basic_first_valid got %0d want %0d", first_valid_k, 3 - HDR); end
        checks++;
        if (done_pulses != 1 || done_k != 8 + HDR)
            begin errors++; $display("FAIL basic_done got pulses=%0d at %0d want 1 at %0d", done_pulses, done_k, 8 + HDR); end
        checks++;
        if (hold_errs != 0 || timeout != 0)
            begin errors++; $display("FAIL basic_hold got hold_errs=%0d timeout=%0d want 0/0", hold_errs, timeout); end
    endtask

    task automatic test_wrap();
        fill_mem();
        do_dump(8'd1, 3, 100, -1, 0, -1);
        checks++;
        if (got_addr.size() != 3)
            begin errors++; $display("FAIL wrap_addr_count got %0d want 3", got_addr.size()); end
        else begin
            checks++;
            if ({got_addr[0], got_addr[1], got_addr[2]} !== {8'd1, 8'd0, 8'd255})
                begin errors++; $display("FAIL wrap_addr got %0d %0d %0d want 1 0 255", got_addr[0], got_addr[1], got_addr[2]); end
        end
        checks++;
        if (got_data.size() != 3 + HDR)
            begin errors++; $display("FAIL wrap_count got %0d want %0d", got_data.size(), 3 + HDR); end
        else begin
            checks++;
            if ({got_data[HDR], got_data[HDR+1], got_data[HDR+2]} !== {mem[1], mem[0], mem[255]})
                begin errors++; $display("FAIL wrap_data got %h %h %h want %h %h %h", got_data[HDR], got_data[HDR+1], got_data[HDR+2], mem[1], mem[0], mem[255]); end
        end
    endtask

    task automatic test_backpressure();
        fill_mem();
        build_expected(8'd77, 4);
        do_dump(8'd77, 4, 100, 1 + HDR, 4, -1);
        checks++;
        if (stab_errs != 0)
            begin errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", stab_errs); end
        checks++;
        if (got_data.size() != exp_data.size())
            begin errors++; $display("FAIL bp_count got %0d want %0d", got_data.size(), exp_data.size()); end
        else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                checks++;
                if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
                    begin errors++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_data[i], exp_last[i]); end
            end
        end
        checks++;
        if (done_k != 2 * 4 + 2 + HDR + 4)
            begin errors++; $display("FAIL bp_done_time got %0d want %0d", done_k, 14 + HDR); end
    endtask

    task automatic test_depth_zero();
        fill_mem();
        do_dump(8'd9, 0, 100, -1, 0, -1);
        checks++;
        if (got_data.size() != HDR)
            begin errors++; $display("FAIL d0_count got %0d want %0d", got_data.size(), HDR); end
        else if (HDR == 1) begin
            checks++;
            if (got_data[0] !== 16'd9 || got_last[0] !== 1'b1)
                begin errors++; $display("FAIL d0_header got %h/%b want 0009/1", got_data[0], got_last[0]); end
        end
        checks++;
        if (done_pulses != 1 || done_k != 2 + HDR)
            begin errors++; $display("FAIL d0_done got pulses=%0d at %0d want 1 at %0d", done_pulses, done_k, 2 + HDR); end
        checks++;
        if (hold_errs != 0)
            begin errors++; $display("FAIL d0_hold got %0d bad cycles want 0", hold_errs); end
    endtask

    task automatic test_full_depth();
        bit seen [NENT];
        int uniq;
        for (int r = 0; r < 2; r++) begin
            fill_mem();
            do_dump(SAW'($urandom), (r == 0) ? 256 : 300 + r * 100, 100, -1, 0, -1);
            for (int i = 0; i < NENT; i++) seen[i] = 0;
            uniq = 0;
            foreach (got_addr[i]) if (!seen[got_addr[i]]) begin seen[got_addr[i]] = 1; uniq++; end
            checks++;
            if (got_addr.size() != NENT || uniq != NENT)
                begin errors++; $display("FAIL full%0d_addrs got %0d reads %0d unique want 256/256", r, got_addr.size(), uniq); end
            checks++;
            if (got_data.size() != NENT + HDR || got_last[got_last.size()-1] !== 1'b1)
                begin errors++; $display("FAIL full%0d_beats got %0d want %0d with last", r, got_data.size(), NENT + HDR); end
        end
    endtask

    task automatic test_start_ignored();
        fill_mem();
        build_expected(8'd200, 3);
        do_dump(8'd200, 3, 100, -1, 0, 4);
        checks++;
        if (got_data.size() != exp_data.size() || done_pulses != 1)
            begin errors++; $display("FAIL busy_start got beats=%0d done=%0d want %0d/1", got_data.size(), done_pulses, exp_data.size()); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_queued cycle %0d got busy=%b want 0", i, busy); end
        end
    endtask

    task automatic test_abort();
        int k, dn;
        for (int r = 0; r < 2; r++) begin
            fill_mem();
            @(negedge clk);
            sp = 8'h40; depth = 9'd5; out_ready = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            k = 0;
            if (r == 1) while (!out_valid && k < 20) begin @(negedge clk); k++; end
            checks++;
            if (busy !== 1'b1 || (r == 1 && out_valid !== 1'b1))
                begin errors++; $display("FAIL abort%0d_reach got busy=%b valid=%b want 1/%0d", r, busy, out_valid, r); end
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            checks++;
            if ({busy, hold, out_valid, out_last} !== 4'b0)
                begin errors++; $display("FAIL abort%0d_idle got %b want 0000", r, {busy, hold, out_valid, out_last}); end
            dn = (done === 1'b1) ? 1 : 0;
            repeat (4) begin @(negedge clk); if (done) dn++; end
            checks++;
            if (dn != 0 || busy !== 1'b0)
                begin errors++; $display("FAIL abort%0d_done got pulses=%0d busy=%b want 0/0", r, dn, busy); end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        fill_mem();
        @(negedge clk);
        sp = 8'h10; depth = 9'd4; out_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({hold, out_valid, busy} !== 3'b0)
            begin errors++; $display("FAIL rst_mid got hold/valid/busy=%b want 000", {hold, out_valid, busy}); end
        @(negedge clk);
        reset_n = 1'b1;
        build_expected(8'h33, 2);
        do_dump(8'h33, 2, 100, -1, 0, -1);
        checks++;
        if (got_data.size() != exp_data.size())
            begin errors++; $display("FAIL rst_after_count got %0d want %0d", got_data.size(), exp_data.size()); end
        else begin
            checks++;
            if (got_data[HDR] !== exp_data[HDR] || got_data[HDR+1] !== exp_data[HDR+1])
                begin errors++; $display("FAIL rst_after_data got %h %h want %h %h", got_data[HDR], got_data[HDR+1], exp_data[HDR], exp_data[HDR+1]); end
        end
    endtask

    task automatic test_random();
        logic [SAW-1:0] spv;
        int dep, sel, pct;
        for (int t = 0; t < 20; t++) begin
            fill_mem();
            spv = SAW'($urandom);
            sel = $urandom_range(9);
            dep = (sel == 0) ? 0 : (sel == 1) ? 257 + $urandom_range(254) :
                  (sel == 2) ? 256 : $urandom_range(1, 12);
            pct = $urandom_range(30, 100);
            build_expected(spv, dep);
            do_dump(spv, dep, pct, -1, 0, -1);
            checks++;
            if (got_data.size() != exp_data.size())
                begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", t, got_data.size(), exp_data.size()); end
            else begin
                for (int i = 0; i < exp_data.size(); i++) begin
                    checks++;
                    if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i])
                        begin errors++; $display("FAIL rnd%0d_beat%0d got %h/%b want %h/%b", t, i, got_data[i], got_last[i], exp_data[i], exp_last[i]); end
                end
            end
            checks++;
            if (got_addr != exp_addr)
                begin errors++; $display("FAIL rnd%0d_addrs got %0d reads want %0d from sp=%0d", t, got_addr.size(), exp_addr.size(), spv); end
            checks++;
            if (done_pulses != 1 || hold_errs != 0 || stab_errs != 0 || timeout != 0)
                begin errors++; $display("FAIL rnd%0d_ctrl got done=%0d hold_errs=%0d stab=%0d to=%0d want 1/0/0/0", t, done_pulses, hold_errs, stab_errs, timeout); end
        end
    endtask

    initial begin
        out_ready = 1'b0;
        fill_mem();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_depth_zero();
        test_full_depth();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
